// File: rtl/if_fetch.sv
// Two-slot instruction fetch: requests base and base+4 from the instruction bus and presents the packet.
// Zero-wait bus gives packet_valid 4 cycles after fetch_en; flush abandons the packet and drains outstanding beats.
module if_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_inst_1,
  output logic [31:0] if_inst_2,
  output logic        packet_valid,
  output logic        delay_hard,
  output logic        IADEE,
  output logic [31:0] exc_pc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR1 = 3'd1,
    ADDR2 = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [1:0]  out_cnt;
  logic [1:0]  out_cnt_nxt;
  logic        second_beat;
  logic        addr_err;
  logic        req_acc;
  logic        data_vld;
  logic        fetching;
  logic        take_beat;

  assign inst_req     = (state == ADDR1) || (state == ADDR2);
  assign inst_addr    = (state == ADDR2) ? (base + 32'd4) :
                        (state == ADDR1) ? base : 32'd0;
  assign delay_hard   = (state == ADDR1) || (state == ADDR2) ||
                        (state == DATA)  || (state == DRAIN);
  assign packet_valid = (state == DONE) && !flush;
  assign IADEE        = (state == DONE) && addr_err;

  // A data beat with nothing outstanding is stray and must not underflow the counter.
  assign req_acc  = inst_req && inst_addr_ok;
  assign data_vld = inst_data_ok && (out_cnt != 2'd0);
  assign fetching = (state == ADDR1) || (state == ADDR2) || (state == DATA);
  assign take_beat = fetching && data_vld && !flush;

  always_comb begin
    out_cnt_nxt = out_cnt;
    if (req_acc && !data_vld)
      out_cnt_nxt = out_cnt + 2'd1;
    else if (!req_acc && data_vld)
      out_cnt_nxt = out_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base        <= 32'd0;
      out_cnt     <= 2'd0;
      second_beat <= 1'b0;
      addr_err    <= 1'b0;
      if_inst_1   <= 32'd0;
      if_inst_2   <= 32'd0;
      exc_pc      <= 32'd0;
    end else begin
      out_cnt <= out_cnt_nxt;

      if (take_beat) begin
        if (!second_beat)
          if_inst_1 <= inst_rdata;
        else
          if_inst_2 <= inst_rdata;
        second_beat <= ~second_beat;
      end

      case (state)
        IDLE: begin
          if (!flush && fetch_en) begin
            base        <= fetch_pc;
            second_beat <= 1'b0;
            if (fetch_pc[1:0] != 2'b00) begin
              addr_err <= 1'b1;
              exc_pc   <= fetch_pc;
              state    <= DONE;
            end else begin
              addr_err <= 1'b0;
              state    <= ADDR1;
            end
          end
        end
        ADDR1: begin
          if (flush)
            state <= (out_cnt_nxt == 2'd0) ? IDLE : DRAIN;
          else if (req_acc)
            state <= ADDR2;
        end
        ADDR2: begin
          if (flush)
            state <= (out_cnt_nxt == 2'd0) ? IDLE : DRAIN;
          else if (take_beat && second_beat)
            state <= DONE;
          else if (req_acc)
            state <= DATA;
        end
        DATA: begin
          if (flush)
            state <= (out_cnt_nxt == 2'd0) ? IDLE : DRAIN;
          else if (take_beat && second_beat)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (out_cnt_nxt == 2'd0)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: stimulus pushes expected packets, a negedge monitor checks every packet_valid.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_inst_1;
  logic [31:0] if_inst_2;
  logic        packet_valid;
  logic        delay_hard;
  logic        IADEE;
  logic [31:0] exc_pc;

  if_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_pc     (fetch_pc),
    .fetch_en     (fetch_en),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_inst_1    (if_inst_1),
    .if_inst_2    (if_inst_2),
    .packet_valid (packet_valid),
    .delay_hard   (delay_hard),
    .IADEE        (IADEE),
    .exc_pc       (exc_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2;
    logic        iadee;
    logic [31:0] epc;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i1, input logic [31:0] i2,
                      input logic iadee, input logic [31:0] epc);
    pkt_t p;
    p.i1 = i1; p.i2 = i2; p.iadee = iadee; p.epc = epc;
    exp_q.push_back(p);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read 1 ns later, still mid-cycle.
  task automatic drive(input logic fe, input logic [31:0] pc, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic fl,
                       input logic rst);
    @(posedge clk);
    #1;
    fetch_en = fe; fetch_pc = pc; inst_addr_ok = aok;
    inst_data_ok = dok; inst_rdata = rd; flush = fl; reset = rst;
    #1;
  endtask

  // Zero-wait fetch; also offers fetch_en while in DONE, which must be ignored.
  task automatic fetch_zero(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
    drive(1, pc, 0, 0, 0, 0, 0);
    chk("idle_req", inst_req, 0);
    push(d1, d2, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("addr1_req", inst_req, 1);
    chk("addr1_addr", inst_addr, pc);
    chk("addr1_delay", delay_hard, 1);
    drive(0, 0, 1, 1, d1, 0, 0);
    chk("addr2_req", inst_req, 1);
    chk("addr2_addr", inst_addr, pc + 32'd4);
    drive(0, 0, 0, 1, d2, 0, 0);
    chk("data_req", inst_req, 0);
    chk("data_delay", delay_hard, 1);
    drive(1, 32'h0000_8000, 0, 0, 0, 0, 0);
    chk("done_pv", packet_valid, 1);
    chk("done_delay", delay_hard, 0);
    chk("done_iadee", IADEE, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("after_done_req", inst_req, 0);
    chk("after_done_delay", delay_hard, 0);
    chk("after_done_pv", packet_valid, 0);
  endtask

  always @(negedge clk) begin
    if (packet_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_packet: got packet_valid=1 inst_1=0x%08h expected no packet", if_inst_1);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("pkt_inst_1", if_inst_1, e.i1);
        chk("pkt_inst_2", if_inst_2, e.i2);
        chk("pkt_iadee", IADEE, e.iadee);
        if (e.iadee) chk("pkt_exc_pc", exc_pc, e.epc);
      end
    end
  end

  initial begin
    reset = 1; fetch_en = 0; fetch_pc = 0; flush = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    repeat (2) @(posedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", inst_req, 0);
    chk("rst_addr", inst_addr, 0);
    chk("rst_delay", delay_hard, 0);
    chk("rst_pv", packet_valid, 0);
    chk("rst_iadee", IADEE, 0);
    chk("rst_inst_1", if_inst_1, 0);
    chk("rst_inst_2", if_inst_2, 0);
    chk("rst_exc_pc", exc_pc, 0);

    // Zero-wait boot fetch.
    fetch_zero(32'hBFC0_0000, 32'h2408_0001, 32'h2409_0002);

    // Misaligned fetch: straight to DONE with an address error, previous packet held.
    drive(1, 32'hBFC0_0382, 0, 0, 0, 0, 0);
    chk("err_idle_req", inst_req, 0);
    push(32'h2408_0001, 32'h2409_0002, 1, 32'hBFC0_0382);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("err_done_req", inst_req, 0);
    chk("err_done_iadee", IADEE, 1);
    chk("err_done_exc_pc", exc_pc, 32'hBFC0_0382);
    chk("err_done_pv", packet_valid, 1);
    chk("err_done_delay", delay_hard, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("err_idle_iadee", IADEE, 0);

    // Back-pressure: 3 stalls in ADDR1, 2 in ADDR2.
    drive(1, 32'h0000_1000, 0, 0, 0, 0, 0);
    push(32'h1111_1111, 32'h2222_2222, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("bp_addr1_req", inst_req, 1);
      chk("bp_addr1_addr", inst_addr, 32'h0000_1000);
      chk("bp_addr1_delay", delay_hard, 1);
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h1111_1111, 0, 0);
    chk("bp_addr2_req", inst_req, 1);
    chk("bp_addr2_addr", inst_addr, 32'h0000_1004);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("bp_addr2_addr_hold", inst_addr, 32'h0000_1004);
    chk("bp_addr2_delay", delay_hard, 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h2222_2222, 0, 0);
    chk("bp_data_delay", delay_hard, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("bp_done_pv", packet_valid, 1);

    // Flush in ADDR2 with one beat outstanding: drain it without writing.
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h0000_2000, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("fl_addr2_addr", inst_addr, 32'h0000_2004);
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    chk("fl_drain_delay", delay_hard, 1);
    chk("fl_drain_req", inst_req, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl_idle_delay", delay_hard, 0);
    chk("fl_inst_1_kept", if_inst_1, 32'h1111_1111);
    chk("fl_inst_2_kept", if_inst_2, 32'h2222_2222);

    // Flush in ADDR1 together with addr_ok: that request is still drained.
    drive(1, 32'h0000_2800, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl1_drain_delay", delay_hard, 1);
    drive(0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0);
    chk("fl1_drain_hold", delay_hard, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl1_idle_delay", delay_hard, 0);
    chk("fl1_inst_1_kept", if_inst_1, 32'h1111_1111);

    // Normal fetch after flushes.
    fetch_zero(32'h0000_3000, 32'h3333_3333, 32'h4444_4444);

    // Address wrap, with simultaneous addr_ok and data_ok in ADDR2.
    fetch_zero(32'hFFFF_FFFC, 32'h5555_5555, 32'h6666_6666);

    // Reset in DATA with one beat outstanding; the late beat is ignored.
    drive(1, 32'h0000_4000, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 32'h7777_7777, 0, 0);
    drive(1, 32'h0000_5000, 0, 0, 0, 1, 1);
    chk("mid_data_delay", delay_hard, 1);
    drive(0, 0, 0, 1, 32'h8888_8888, 0, 0);
    chk("mrst_req", inst_req, 0);
    chk("mrst_addr", inst_addr, 0);
    chk("mrst_delay", delay_hard, 0);
    chk("mrst_pv", packet_valid, 0);
    chk("mrst_iadee", IADEE, 0);
    chk("mrst_inst_1", if_inst_1, 0);
    chk("mrst_inst_2", if_inst_2, 0);
    chk("mrst_exc_pc", exc_pc, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("late_inst_1", if_inst_1, 0);
    chk("late_delay", delay_hard, 0);
    chk("late_req", inst_req, 0);

    repeat (3) @(posedge clk);
    chk("packets_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
